pingpong_bank_loader: RTL and testbench

//   Upstream feeder for the 64-to-32 word bank selector. Accepts a serial stream of

---
 rtl/pingpong_bank_loader.sv | 164 ++++++++++++++++
 tb/tb_pingpong_bank_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pingpong_bank_loader.sv
// Ping-pong bank loader: fills two DEPTH-word register banks alternately from a
// valid/ready word stream and steers the downstream bank selector so that it
// always shows the most recently completed bank. The displayed bank is never
// written while the consumer holds it (held=1).
//
// Note: the consumer-release input is named release_i because "release" is a
// reserved word in SystemVerilog.

// One register bank: DEPTH words packed flat, word i at [i*WORD_W +: WORD_W].
module pingpong_bank_loader_bank #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic [WORD_W-1:0]       wdata_i,
    output logic [DEPTH*WORD_W-1:0] flat_o
);
    logic [DEPTH*WORD_W-1:0] data_q;

    // Bank storage: cleared on reset, single word written per accepted beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (we_i) begin
            data_q[idx_i*WORD_W +: WORD_W] <= wdata_i;
        end
    end

    assign flat_o = data_q;
endmodule

module pingpong_bank_loader #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [WORD_W-1:0]       in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    release_i,
    output logic [DEPTH*WORD_W-1:0] bank0_flat_o,
    output logic [DEPTH*WORD_W-1:0] bank1_flat_o,
    output logic                    sel_o,
    output logic                    held_o,
    output logic                    wr_bank_o,
    output logic                    rel_err_o
);
    localparam int IDX_W = $clog2(DEPTH);

    // FILL accepts words; WAIT parks a completed bank until the consumer
    // releases the displayed one.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_bank_q, wr_bank_d;
    logic             sel_q, sel_d;
    logic             held_q, held_d;
    logic             rel_err_q, rel_err_d;

    logic             hs;
    logic             last_word;
    logic [1:0][DEPTH*WORD_W-1:0] bank_flat;

    assign in_ready_o = (state_q == ST_FILL) & ~rst_i;
    assign hs         = in_valid_i & in_ready_o;
    assign last_word  = (wr_idx_q == IDX_W'(DEPTH - 1));

    // Two bank instances; only the bank being filled sees the write strobe.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        pingpong_bank_loader_bank #(
            .WORD_W (WORD_W),
            .DEPTH  (DEPTH),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .we_i    (hs & (wr_bank_q == 1'(b))),
            .idx_i   (wr_idx_q),
            .wdata_i (in_data_i),
            .flat_o  (bank_flat[b])
        );
    end

    assign bank0_flat_o = bank_flat[0];
    assign bank1_flat_o = bank_flat[1];

    // Control state register; reset discards any partial fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_FILL;
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            sel_q     <= 1'b0;
            held_q    <= 1'b0;
            rel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            sel_q     <= sel_d;
            held_q    <= held_d;
            rel_err_q <= rel_err_d;
        end
    end

    // Next-state: advance the fill index, swap banks on completion when the
    // display is free (or freed this cycle), otherwise park in WAIT.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        sel_d     = sel_q;
        held_d    = held_q;
        rel_err_d = rel_err_q;
        unique case (state_q)
            ST_FILL: begin
                if (hs) begin
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                end
                if (hs && last_word) begin
                    if (!held_q || release_i) begin
                        // A same-cycle release is consumed by this swap.
                        sel_d     = wr_bank_q;
                        held_d    = 1'b1;
                        wr_bank_d = ~wr_bank_q;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (release_i) begin
                    if (held_q) begin
                        held_d = 1'b0;
                    end else begin
                        rel_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // held is always 1 here, so a release is never an error.
                if (release_i) begin
                    sel_d     = wr_bank_q;
                    wr_bank_d = ~wr_bank_q;
                    state_d   = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign sel_o     = sel_q;
    assign held_o    = held_q;
    assign wr_bank_o = wr_bank_q;
    assign rel_err_o = rel_err_q;
endmodule

// File: tb/tb_pingpong_bank_loader.sv
// Directed bench for pingpong_bank_loader with WORD_W=32, DEPTH=32.
module tb_pingpong_bank_loader;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [WORD_W-1:0]       in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    rel = 1'b0;
    logic [DEPTH*WORD_W-1:0] bank0_flat, bank1_flat;
    logic                    sel, held, wr_bank, rel_err;

    int checks   = 0;
    int failures = 0;

    pingpong_bank_loader #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .release_i    (rel),
        .bank0_flat_o (bank0_flat),
        .bank1_flat_o (bank1_flat),
        .sel_o        (sel),
        .held_o       (held),
        .wr_bank_o    (wr_bank),
        .rel_err_o    (rel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] w0(input int i);
        return bank0_flat[i*WORD_W +: WORD_W];
    endfunction

    function automatic logic [WORD_W-1:0] w1(input int i);
        return bank1_flat[i*WORD_W +: WORD_W];
    endfunction

    // One beat; returns #1 after the edge so the next beat is back-to-back.
    task automatic send(input logic [WORD_W-1:0] d, input logic r);
        in_valid = 1'b1;
        in_data  = d;
        rel      = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rel      = 1'b0;
    endtask

    task automatic pulse_release();
        rel = 1'b1;
        @(posedge clk); #1;
        rel = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("ready_in_rst", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        chk("ready_in_rst0", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_held", 64'(held), 64'd0);
        chk("rst_wrbank", 64'(wr_bank), 64'd0);
        chk("rst_relerr", 64'(rel_err), 64'd0);
        chk("rst_bank0", 64'(bank0_flat == '0), 64'd1);
        chk("rst_bank1", 64'(bank1_flat == '0), 64'd1);

        // 2: fill bank0, gap-free
        for (int i = 0; i < DEPTH; i++) begin
            send(32'h100 + 32'(i), 1'b0);
            if (i == 0) chk("b0_first_visible", 64'(w0(0)), 64'h100);
            if (i < DEPTH - 1) chk("held_during_fill", 64'(held), 64'd0);
        end
        for (int i = 0; i < DEPTH; i++) chk($sformatf("b0_w%0d", i), 64'(w0(i)), 64'(32'h100 + 32'(i)));
        chk("t2_sel", 64'(sel), 64'd0);
        chk("t2_held", 64'(held), 64'd1);
        chk("t2_wrbank", 64'(wr_bank), 64'd1);
        chk("t2_ready", 64'(in_ready), 64'd1);

        // 3: fill bank1 without release -> WAIT
        for (int i = 0; i < DEPTH; i++) send(32'h200 + 32'(i), 1'b0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("b1_w%0d", i), 64'(w1(i)), 64'(32'h200 + 32'(i)));
        chk("t3_wait_ready", 64'(in_ready), 64'd0);
        chk("t3_sel", 64'(sel), 64'd0);
        chk("t3_held", 64'(held), 64'd1);
        chk("t3_wrbank", 64'(wr_bank), 64'd1);
        // in_valid ignored in WAIT
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t3_wait_b1w0", 64'(w1(0)), 64'h200);
        chk("t3_wait_b0w0", 64'(w0(0)), 64'h100);
        chk("t3_wait_still", 64'(in_ready), 64'd0);
        pulse_release();
        chk("t3_rel_sel", 64'(sel), 64'd1);
        chk("t3_rel_held", 64'(held), 64'd1);
        chk("t3_rel_wrbank", 64'(wr_bank), 64'd0);
        chk("t3_rel_ready", 64'(in_ready), 64'd1);
        chk("t3_b0_w31", 64'(w0(31)), 64'h11F);
        chk("t3_relerr", 64'(rel_err), 64'd0);

        // 4: release on the completing handshake -> swap, no WAIT
        for (int i = 0; i < DEPTH; i++) send(32'h300 + 32'(i), (i == DEPTH - 1));
        chk("t4_sel", 64'(sel), 64'd0);
        chk("t4_held", 64'(held), 64'd1);
        chk("t4_wrbank", 64'(wr_bank), 64'd1);
        chk("t4_ready", 64'(in_ready), 64'd1);
        chk("t4_b0_w0", 64'(w0(0)), 64'h300);
        chk("t4_b0_w31", 64'(w0(31)), 64'h31F);
        chk("t4_b1_w5", 64'(w1(5)), 64'h205);
        chk("t4_relerr", 64'(rel_err), 64'd0);

        // 5: reset mid-fill of bank1
        for (int i = 0; i < 10; i++) send(32'h400 + 32'(i), 1'b0);
        chk("t5_b1_w9", 64'(w1(9)), 64'h409);
        chk("t5_b1_w10", 64'(w1(10)), 64'h20A);
        do_reset();
        chk("t5_bank0", 64'(bank0_flat == '0), 64'd1);
        chk("t5_bank1", 64'(bank1_flat == '0), 64'd1);
        chk("t5_sel", 64'(sel), 64'd0);
        chk("t5_held", 64'(held), 64'd0);
        chk("t5_wrbank", 64'(wr_bank), 64'd0);
        send(32'h555, 1'b0);
        chk("t5_b0_w0", 64'(w0(0)), 64'h555);
        chk("t5_b0_w1", 64'(w0(1)), 64'h0);
        chk("t5_b1_w0", 64'(w1(0)), 64'h0);

        // 6: release with held=0 -> sticky rel_err; gapped fill
        pulse_release();
        chk("t6_relerr", 64'(rel_err), 64'd1);
        chk("t6_held", 64'(held), 64'd0);
        for (int i = 1; i < DEPTH; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send(32'h500 + 32'(i), 1'b0);
        end
        chk("t6_w0", 64'(w0(0)), 64'h555);
        for (int i = 1; i < DEPTH; i++) chk($sformatf("t6_w%0d", i), 64'(w0(i)), 64'(32'h500 + 32'(i)));
        chk("t6_b1_zero", 64'(bank1_flat == '0), 64'd1);
        chk("t6_sel", 64'(sel), 64'd0);
        chk("t6_held", 64'(held), 64'd1);
        chk("t6_wrbank", 64'(wr_bank), 64'd1);
        chk("t6_relerr_sticky", 64'(rel_err), 64'd1);
        do_reset();
        chk("t6_relerr_clr", 64'(rel_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
